// File: rtl/nvdla_ssync_tgl_rx.sv
// nvdla_ssync_tgl_rx
//   Destination-domain consumer of a toggle-encoded event stream that has already
//   passed through a 3-flop synchronizer. Every transition of the synchronized
//   level is one source event. Events are counted into a saturating pending
//   counter and handed to a local consumer over a valid/ready handshake.
//
// Parameters
//   CNT_W      width of the pending counter; at most 2^CNT_W-1 events are queued.
//
// Optional build macro
//   NVDLA_SSYNC_TGL_RX_STAT_EN  when defined, evt_total counts accepted pops
//                               (16-bit, wrapping, cleared by reset only);
//                               otherwise evt_total is tied to zero.
//
// Ports
//   o_clk      destination clock
//   o_rstn     asynchronous active-low reset
//   sync_tgl   synchronized toggle level (each edge = one event)
//   enable     1 = accept events, 0 = drop edges (level still tracked)
//   flush      synchronous clear of the pending count
//   evt_valid  at least one event pending
//   evt_ready  consumer takes one event when evt_valid & evt_ready
//   evt_pend   current pending count
//   evt_ovf    sticky overflow flag
//   ovf_clr    synchronous clear of evt_ovf (a same-cycle set wins)
//   evt_total  total accepted events (statistics build only)

module nvdla_ssync_tgl_rx #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             o_clk,
    input  logic             o_rstn,
    input  logic             sync_tgl,
    input  logic             enable,
    input  logic             flush,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_pend,
    output logic             evt_ovf,
    input  logic             ovf_clr,
    output logic [15:0]      evt_total
);

    localparam logic [CNT_W-1:0] PendMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PendOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             tgl_q;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             edge_det;
    logic             inc;
    logic             pop;
    logic             ovf_set;

    // Decoded from the register only: no combinational path from evt_ready or sync_tgl.
    assign evt_valid = (pend_q != '0);
    assign evt_pend  = pend_q;
    assign evt_ovf   = ovf_q;

    assign edge_det = sync_tgl ^ tgl_q;
    assign inc      = edge_det & enable;
    assign pop      = evt_valid & evt_ready;

    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (flush) begin
            // Flush discards the queue; a same-cycle edge or pop is lost, never an overflow.
            pend_d = '0;
        end else if (inc && !pop) begin
            if (pend_q == PendMax) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PendOne;
            end
        end else if (pop && !inc) begin
            pend_d = pend_q - PendOne;
        end
        // inc & pop cancel: pend holds.
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge o_clk or negedge o_rstn) begin
        if (!o_rstn) begin
            tgl_q  <= 1'b0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            // Level is tracked even while disabled so re-enabling makes no spurious event.
            tgl_q  <= sync_tgl;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef NVDLA_SSYNC_TGL_RX_STAT_EN
    logic [15:0] total_q, total_d;

    // A pop coinciding with flush is discarded together with the queue.
    always_comb begin
        total_d = total_q;
        if (pop && !flush) begin
            total_d = total_q + 16'd1;
        end
    end

    always_ff @(posedge o_clk or negedge o_rstn) begin
        if (!o_rstn) begin
            total_q <= 16'h0000;
        end else begin
            total_q <= total_d;
        end
    end

    assign evt_total = total_q;
`else
    assign evt_total = 16'h0000;
`endif

endmodule

// File: tb/tb_nvdla_ssync_tgl_rx.sv
// Self-checking bench for nvdla_ssync_tgl_rx: directed scenarios followed by
// random traffic, all compared against an arithmetic event-count model.

module tb_nvdla_ssync_tgl_rx;

    localparam int unsigned CNT_W = 4;
    localparam int MAX = (1 << CNT_W) - 1;

    logic             o_clk = 1'b0;
    logic             o_rstn;
    logic             sync_tgl;
    logic             enable;
    logic             flush;
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_pend;
    logic             evt_ovf;
    logic             ovf_clr;
    logic [15:0]      evt_total;

    nvdla_ssync_tgl_rx #(
        .CNT_W (CNT_W)
    ) u_dut (
        .o_clk     (o_clk),
        .o_rstn    (o_rstn),
        .sync_tgl  (sync_tgl),
        .enable    (enable),
        .flush     (flush),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_pend  (evt_pend),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr),
        .evt_total (evt_total)
    );

    always #5 o_clk = ~o_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: number of queued events as a plain integer.
    int m_pend;
    bit m_ovf;
    bit m_lvl;
    int m_total;
    bit lvl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_ovf   = 1'b0;
        m_lvl   = 1'b0;
        m_total = 0;
    endtask

    task automatic model_step(input bit s, input bit en, input bit fl, input bit rdy,
                              input bit oc);
        bit took;
        bit ovf_hit;
        int nxt;
        took    = (m_pend > 0) && rdy;
        ovf_hit = 1'b0;
        if (fl) begin
            nxt = 0;
        end else begin
            nxt = m_pend + ((s != m_lvl && en) ? 1 : 0) - (took ? 1 : 0);
            if (nxt > MAX) begin
                nxt     = MAX;
                ovf_hit = 1'b1;
            end
            if (took) m_total = (m_total + 1) % 65536;
        end
        m_pend = nxt;
        if (ovf_hit) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        m_lvl = s;
    endtask

    task automatic check_all(input string where);
        check_eq({where, " pend"}, 32'(evt_pend), 32'(m_pend));
        check_eq({where, " valid"}, 32'(evt_valid), 32'(m_pend != 0));
        check_eq({where, " ovf"}, 32'(evt_ovf), 32'(m_ovf));
`ifdef NVDLA_SSYNC_TGL_RX_STAT_EN
        check_eq({where, " total"}, 32'(evt_total), 32'(m_total));
`else
        check_eq({where, " total"}, 32'(evt_total), 32'h0);
`endif
    endtask

    // One clock: drive at negedge, model the edge, compare 1 ns after posedge.
    task automatic cyc(input string where, input bit s, input bit en, input bit fl,
                       input bit rdy, input bit oc);
        @(negedge o_clk);
        sync_tgl  = s;
        enable    = en;
        flush     = fl;
        evt_ready = rdy;
        ovf_clr   = oc;
        model_step(s, en, fl, rdy, oc);
        @(posedge o_clk);
        #1;
        check_all(where);
    endtask

    task automatic tog(input string where, input bit en, input bit fl, input bit rdy,
                       input bit oc);
        lvl = ~lvl;
        cyc(where, lvl, en, fl, rdy, oc);
    endtask

    initial begin
        o_rstn    = 1'b0;
        sync_tgl  = 1'b0;
        enable    = 1'b0;
        flush     = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        lvl       = 1'b0;
        model_reset();
        repeat (2) @(posedge o_clk);
        #1;
        check_all("reset");
        @(negedge o_clk);
        o_rstn = 1'b1;

        // Single event appears one cycle after the edge.
        tog("first", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("first pend const", 32'(evt_pend), 32'd1);
        cyc("drain1", lvl, 1'b1, 1'b0, 1'b1, 1'b0);

        // Three events then three pops.
        repeat (3) tog("fill3", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("fill3 const", 32'(evt_pend), 32'd3);
        repeat (3) cyc("pop3", lvl, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("pop3 valid const", 32'(evt_valid), 32'd0);

        // Saturation and overflow handling.
        repeat (16) tog("sat", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("sat pend const", 32'(evt_pend), 32'(MAX));
        check_eq("sat ovf const", 32'(evt_ovf), 32'd1);
        cyc("ovfclr", lvl, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("ovfclr const", 32'(evt_ovf), 32'd0);
        tog("sat_clr", 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("set beats clr", 32'(evt_ovf), 32'd1);

        // Simultaneous inc and pop hold; flush with a toggle clears with no overflow.
        cyc("flush0", lvl, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (5) tog("fill5", 1'b1, 1'b0, 1'b0, 1'b0);
        tog("incpop", 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("incpop const", 32'(evt_pend), 32'd5);
        tog("flushtog", 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("flushtog const", 32'(evt_pend), 32'd0);
        check_eq("flushtog ovf", 32'(evt_ovf), 32'd0);

        // Disabled edges are dropped; re-enable makes no spurious event.
        repeat (4) tog("dis", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc("reen", lvl, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("reen const", 32'(evt_pend), 32'd0);
        tog("reen_tog", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("reen_tog const", 32'(evt_pend), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit s;
            s = ($urandom_range(0, 9) < 6) ? ~lvl : lvl;
            lvl = s;
            cyc("rand", s, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 20 : 60),
                $urandom_range(0, 99) < 5);
        end

        // Build pend=7 with evt_ovf=1, then asynchronous reset.
        cyc("pre_rst", lvl, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (16) tog("rst_fill", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) cyc("rst_pop", lvl, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("pre-rst pend", 32'(evt_pend), 32'd7);
        check_eq("pre-rst ovf", 32'(evt_ovf), 32'd1);
        #2;
        o_rstn = 1'b0;
        #1;
        check_eq("async valid", 32'(evt_valid), 32'd0);
        check_eq("async pend", 32'(evt_pend), 32'd0);
        check_eq("async ovf", 32'(evt_ovf), 32'd0);
        check_eq("async total", 32'(evt_total), 32'd0);
        model_reset();
        o_rstn = 1'b1;
        // Level held at 1 through release counts as one event against tgl_q=0.
        lvl = 1'b1;
        cyc("post_rst", lvl, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("post_rst const", 32'(evt_pend), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
